// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the i2c_master request arbiter.
package i2c_arb_pkg;

  localparam int unsigned I2C_SLAVE_W = 7;
  localparam int unsigned I2C_BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [I2C_SLAVE_W-1:0] slave;
    logic [I2C_BYTE_W-1:0]  reg_addr;
    logic [I2C_BYTE_W-1:0]  wdata;
  } i2c_cmd_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Index width that stays at least one bit for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_rr.sv
// Round-robin arbiter: onehot grant starting the search at a rotating pointer.
module rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters, one single-byte register
// transaction at a time, with busy-detect and completion timeout.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 2,
  parameter int unsigned BUSY_WAIT_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 20000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ-1:0]             i_req_write,
  input  logic [NUM_REQ*I2C_SLAVE_W-1:0] i_req_slave,
  input  logic [NUM_REQ*I2C_BYTE_W-1:0]  i_req_reg,
  input  logic [NUM_REQ*I2C_BYTE_W-1:0]  i_req_wdata,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [I2C_BYTE_W-1:0]          o_rsp_data,
  output logic                           o_rsp_timeout,
  output logic                           o_i2c_we,
  output logic                           o_i2c_re,
  output logic [I2C_SLAVE_W-1:0]         o_i2c_slave_address,
  output logic [I2C_BYTE_W-1:0]          o_i2c_rw_address,
  output logic [I2C_BYTE_W-1:0]          o_i2c_write_data,
  input  logic [I2C_BYTE_W-1:0]          i_i2c_read_data,
  input  logic                           i_i2c_ready
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W =
    $clog2(max_u(max_u(TIMEOUT_CYCLES, BUSY_WAIT_CYCLES), 1) + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST =
    CNT_W'((BUSY_WAIT_CYCLES == 0) ? 32'd0 : BUSY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  i2c_cmd_t                cmd_q, cmd_d, sel_cmd;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic                    we_q, we_d, re_q, re_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [I2C_BYTE_W-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_to_q, rsp_to_d;

  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    arb_open;
  logic                    accept;

  // Grants only while idle, with the master free and out of reset.
  assign arb_open    = (state_q == IDLE) && i_i2c_ready && i_rst_n;
  assign o_req_ready = grant & {NUM_REQ{arb_open}};
  assign accept      = |o_req_ready;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .req       (i_req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  // Command fields of the current round-robin winner.
  always_comb begin
    sel_cmd.write    = i_req_write[gnt_idx];
    sel_cmd.slave    = i_req_slave[32'(gnt_idx)*I2C_SLAVE_W +: I2C_SLAVE_W];
    sel_cmd.reg_addr = i_req_reg[32'(gnt_idx)*I2C_BYTE_W +: I2C_BYTE_W];
    sel_cmd.wdata    = i_req_wdata[32'(gnt_idx)*I2C_BYTE_W +: I2C_BYTE_W];
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    owner_d     = owner_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_to_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d   = sel_cmd;
          owner_d = gnt_idx;
          we_d    = sel_cmd.write;
          re_d    = !sel_cmd.write;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end

      // A master that never drops ready is treated as a completed no-op.
      WAIT_BUSY: begin
        if (!i_i2c_ready) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (BUSY_WAIT_CYCLES == 0 || cnt_q == BUSY_LAST) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = cmd_q.write ? '0 : i_i2c_read_data;
          state_d              = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_DONE: begin
        if (i_i2c_ready) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = cmd_q.write ? '0 : i_i2c_read_data;
          state_d              = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_to_d             = 1'b1;
          state_d              = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      owner_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign o_i2c_we            = we_q;
  assign o_i2c_re            = re_q;
  assign o_i2c_slave_address = cmd_q.slave;
  assign o_i2c_rw_address    = cmd_q.reg_addr;
  assign o_i2c_write_data    = cmd_q.wdata;
  assign o_rsp_valid         = rsp_valid_q;
  assign o_rsp_data          = rsp_data_q;
  assign o_rsp_timeout       = rsp_to_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: two instances (long and short timeout), each
// driving a behavioural i2c_master that drops ready one cycle after enable.
module tb_i2c_master_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  valid [2];
  logic [1:0]  write;
  logic [13:0] slaves;
  logic [15:0] regs;
  logic [15:0] wdatas;

  logic [1:0] req_ready [2];
  logic [1:0] rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       rsp_to    [2];
  logic       i2c_we    [2];
  logic       i2c_re    [2];
  logic [6:0] o_slave   [2];
  logic [7:0] o_reg     [2];
  logic [7:0] o_wdata   [2];
  logic       rdy       [2];
  logic [7:0] rdata     [2];

  int         d_cfg     [2];
  logic [7:0] mdata_cfg [2];
  logic       rel_req   [2];
  logic       force_low [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural master: ready low for d_cfg cycles starting one cycle after an enable.
  for (genvar g = 0; g < 2; g++) begin : g_model
    logic       mready;
    int         mcnt;
    logic [7:0] mrdata;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mready <= 1'b1;
        mcnt   <= 0;
        mrdata <= 8'h00;
      end else if (rel_req[g]) begin
        mready <= 1'b1;
        mcnt   <= 0;
      end else if (i2c_we[g] || i2c_re[g]) begin
        mrdata <= mdata_cfg[g];
        if (d_cfg[g] > 0) begin
          mready <= 1'b0;
          mcnt   <= d_cfg[g];
        end
      end else if (!mready) begin
        if (mcnt <= 1) mready <= 1'b1;
        else           mcnt   <= mcnt - 1;
      end
    end
    assign rdy[g]   = mready & ~force_low[g];
    assign rdata[g] = mrdata;
  end

  i2c_master_arbiter #(.NUM_REQ(2), .BUSY_WAIT_CYCLES(4), .TIMEOUT_CYCLES(20000)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid[0]), .o_req_ready(req_ready[0]), .i_req_write(write),
    .i_req_slave(slaves), .i_req_reg(regs), .i_req_wdata(wdatas),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data[0]), .o_rsp_timeout(rsp_to[0]),
    .o_i2c_we(i2c_we[0]), .o_i2c_re(i2c_re[0]),
    .o_i2c_slave_address(o_slave[0]), .o_i2c_rw_address(o_reg[0]),
    .o_i2c_write_data(o_wdata[0]), .i_i2c_read_data(rdata[0]), .i_i2c_ready(rdy[0])
  );

  i2c_master_arbiter #(.NUM_REQ(2), .BUSY_WAIT_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid[1]), .o_req_ready(req_ready[1]), .i_req_write(write),
    .i_req_slave(slaves), .i_req_reg(regs), .i_req_wdata(wdatas),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data[1]), .o_rsp_timeout(rsp_to[1]),
    .o_i2c_we(i2c_we[1]), .o_i2c_re(i2c_re[1]),
    .o_i2c_slave_address(o_slave[1]), .o_i2c_rw_address(o_reg[1]),
    .o_i2c_write_data(o_wdata[1]), .i_i2c_read_data(rdata[1]), .i_i2c_ready(rdy[1])
  );

  typedef struct {
    int          sel;
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [13:0] slaves;
    logic [15:0] regs;
    logic [15:0] wdatas;
    int          d;
    logic [7:0]  mdata;
    int          owner;
    logic        we;
    logic        re;
    logic [6:0]  slave;
    logic [7:0]  rega;
    logic [7:0]  wdata;
    logic [7:0]  data;
    logic        tmo;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input logic [1:0] v, input logic [1:0] w,
                              input logic [13:0] s, input logic [15:0] r, input logic [15:0] wd,
                              input int d, input logic [7:0] md, input int own,
                              input logic ewe, input logic ere, input logic [6:0] es,
                              input logic [7:0] er, input logic [7:0] ew, input logic [7:0] edat,
                              input logic eto, input int elat);
    vec_t t;
    t.sel = sel; t.valid = v; t.write = w; t.slaves = s; t.regs = r; t.wdatas = wd;
    t.d = d; t.mdata = md; t.owner = own; t.we = ewe; t.re = ere; t.slave = es;
    t.rega = er; t.wdata = ew; t.data = edat; t.tmo = eto; t.lat = elat;
    return t;
  endfunction

  // One transaction: grant, enable pulse and fields, response latency and payload.
  task automatic do_txn(input vec_t v, input int idx);
    int s;
    int waitc;
    int lat;
    int exp_oh;
    s      = v.sel;
    exp_oh = 1 << v.owner;
    write  = v.write; slaves = v.slaves; regs = v.regs; wdatas = v.wdatas;
    d_cfg[s] = v.d; mdata_cfg[s] = v.mdata;
    valid[s] = v.valid;
    #1;
    waitc = 0;
    while (req_ready[s] == 2'b00 && waitc < 50) begin
      @(negedge clk); #1;
      waitc++;
    end
    chk($sformatf("v%0d grant", idx), 32'(req_ready[s]), 32'(exp_oh));
    @(negedge clk);
    valid[s] = 2'b00;
    chk($sformatf("v%0d we", idx),    32'(i2c_we[s]),  32'(v.we));
    chk($sformatf("v%0d re", idx),    32'(i2c_re[s]),  32'(v.re));
    chk($sformatf("v%0d slave", idx), 32'(o_slave[s]), 32'(v.slave));
    chk($sformatf("v%0d reg", idx),   32'(o_reg[s]),   32'(v.rega));
    chk($sformatf("v%0d wdata", idx), 32'(o_wdata[s]), 32'(v.wdata));
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid[s] == 2'b00 && lat < 400);
    chk($sformatf("v%0d latency", idx),   32'(lat),          32'(v.lat));
    chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid[s]), 32'(exp_oh));
    chk($sformatf("v%0d rsp_data", idx),  32'(rsp_data[s]),  32'(v.data));
    chk($sformatf("v%0d timeout", idx),   32'(rsp_to[s]),    32'(v.tmo));
    @(negedge clk);
    chk($sformatf("v%0d rsp_pulse", idx), 32'(rsp_valid[s]), 32'd0);
  endtask

  int pulses;

  initial begin
    // sel valid write slaves{1,0} regs{1,0} wdatas{1,0} D mdata | owner we re slave reg wdata data tmo lat
    vecs[0] = mk(0, 2'b11, 2'b00, {7'h22, 7'h50}, {8'h33, 8'h11}, 16'h0000, 3, 8'h11,
                 0, 1'b0, 1'b1, 7'h50, 8'h11, 8'h00, 8'h11, 1'b0, 6);
    vecs[1] = mk(0, 2'b11, 2'b00, {7'h22, 7'h50}, {8'h33, 8'h11}, 16'h0000, 3, 8'h22,
                 1, 1'b0, 1'b1, 7'h22, 8'h33, 8'h00, 8'h22, 1'b0, 6);
    vecs[2] = mk(0, 2'b11, 2'b00, {7'h22, 7'h50}, {8'h33, 8'h11}, 16'h0000, 3, 8'h33,
                 0, 1'b0, 1'b1, 7'h50, 8'h11, 8'h00, 8'h33, 1'b0, 6);
    vecs[3] = mk(0, 2'b11, 2'b00, {7'h22, 7'h50}, {8'h33, 8'h11}, 16'h0000, 3, 8'h44,
                 1, 1'b0, 1'b1, 7'h22, 8'h33, 8'h00, 8'h44, 1'b0, 6);
    vecs[4] = mk(0, 2'b01, 2'b00, {7'h22, 7'h50}, {8'h33, 8'h10}, 16'h0000, 100, 8'hA5,
                 0, 1'b0, 1'b1, 7'h50, 8'h10, 8'h00, 8'hA5, 1'b0, 103);
    vecs[5] = mk(0, 2'b10, 2'b10, {7'h1D, 7'h50}, {8'h2A, 8'h10}, 16'h3C00, 5, 8'h77,
                 1, 1'b1, 1'b0, 7'h1D, 8'h2A, 8'h3C, 8'h00, 1'b0, 8);
    vecs[6] = mk(0, 2'b01, 2'b00, {7'h1D, 7'h42}, {8'h2A, 8'h07}, 16'h0000, 0, 8'h5A,
                 0, 1'b0, 1'b1, 7'h42, 8'h07, 8'h00, 8'h5A, 1'b0, 6);
    vecs[7] = mk(1, 2'b01, 2'b00, {7'h1D, 7'h60}, {8'h2A, 8'h01}, 16'h3C00, 1000, 8'h99,
                 0, 1'b0, 1'b1, 7'h60, 8'h01, 8'h00, 8'h00, 1'b1, 53);

    for (int i = 0; i < 2; i++) begin
      valid[i] = 2'b00; d_cfg[i] = 0; mdata_cfg[i] = 8'h00;
      rel_req[i] = 1'b0; force_low[i] = 1'b0;
    end
    write = 2'b00; slaves = '0; regs = '0; wdatas = '0;

    #12;
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset enables",   32'({i2c_we[0], i2c_re[0]}), 32'd0);
    chk("reset slave",     32'(o_slave[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_txn(vecs[i], i);

    // After a timeout the master is still busy: nothing granted until ready returns.
    valid[1] = 2'b01;
    repeat (5) begin
      #1 chk("timeout block", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
    end
    rel_req[1] = 1'b1;
    @(posedge clk);
    #1 rel_req[1] = 1'b0;
    @(negedge clk);
    valid[1] = 2'b11;
    #1 chk("timeout regrant", 32'(req_ready[1]), 32'h2);
    valid[1] = 2'b00;
    @(negedge clk);
    valid[1] = 2'b11;
    #1 chk("dropped valid keeps pointer", 32'(req_ready[1]), 32'h2);
    valid[1] = 2'b00;
    @(negedge clk);

    // Busy master blocks grants.
    force_low[0] = 1'b1;
    valid[0] = 2'b01;
    repeat (4) begin
      #1 chk("busy block", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    force_low[0] = 1'b0;
    #1 chk("busy release", 32'(req_ready[0]), 32'h1);
    valid[0] = 2'b00;
    @(negedge clk);

    // Reset during WAIT_DONE aborts silently and restores the pointer.
    write = 2'b00; slaves = {7'h22, 7'h50}; regs = {8'h33, 8'h10}; wdatas = 16'h0000;
    d_cfg[0] = 100; mdata_cfg[0] = 8'hC3;
    valid[0] = 2'b01;
    #1 chk("rst pre grant", 32'(req_ready[0]), 32'h1);
    @(negedge clk);
    valid[0] = 2'b00;
    repeat (8) @(negedge clk);
    chk("rst pre slave", 32'(o_slave[0]), 32'h50);
    valid[0] = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("rst req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst enables",   32'({i2c_we[0], i2c_re[0]}), 32'd0);
    chk("rst slave",     32'(o_slave[0]), 32'd0);
    chk("rst reg",       32'(o_reg[0]), 32'd0);
    chk("rst rsp_data",  32'({rsp_data[0], rsp_to[0]}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst pointer", 32'(req_ready[0]), 32'h1);
    valid[0] = 2'b00;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid[0] != 2'b00) pulses++;
    end
    chk("rst no rsp", 32'(pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
